bit_scan_stream: RTL and testbench
==================================

BIT_SCAN_STREAM -- requirements
Module: bit_scan_stream

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8: input vector width, >= 1.
- MODE, default 1'b0: scan order; 0 = LSB first, 1 = MSB first.
- CNT_WIDTH, default cf_math_pkg::idx_width(WIDTH): derived width of the index and sequence outputs; not to be overridden.
REQ-002 Ports SHALL be:
- clk_i        input   1          single clock; all state updates on rising edge.
- rst_ni       input   1          reset; synchronous, active-low.
- flush_i      input   1          abort the vector in progress.
- in_valid_i   input   1          input vector valid.
- in_ready_o   output  1          block accepts a vector.
- in_i         input   WIDTH      vector whose set bits are to be enumerated.
- out_valid_o  output  1          index beat valid.
- out_ready_i  input   1          consumer accepts the beat.
- idx_o        output  CNT_WIDTH  absolute bit position in in_i of the current set bit.
- seq_o        output  CNT_WIDTH  ordinal of the current beat within its vector, starting at 0.
- last_o       output  1          current beat is the final beat of its vector.
- zero_o       output  1          current beat reports an all-zero vector (see Configuration).
- busy_o       output  1          a vector is held (state SCAN).

Function
REQ-003 The block SHALL have two states. IDLE means no vector is held. SCAN means a remaining-bits register rem_q is non-zero or a zero beat is pending.
REQ-004 An input handshake SHALL occur when in_valid_i & in_ready_o. On it, rem_q <= in_i and the seq counter <= 0.
REQ-005 in_ready_o SHALL equal !flush_i & (IDLE | (out_valid_o & out_ready_i & last_o)). This allows a new vector to be accepted in the same cycle as the previous last beat, so there is no bubble.
REQ-006 out_valid_o SHALL equal SCAN & !flush_i, so the first beat is valid in the cycle after acceptance (latency 1).
REQ-007 idx_o SHALL be the position of the lowest set bit of rem_q when MODE=0, and of the highest set bit when MODE=1. It SHALL be 0 when out_valid_o=0.
REQ-008 last_o SHALL be 1 when exactly one bit of rem_q is set, or when a zero beat is presented. It SHALL be 0 when out_valid_o=0.
REQ-009 On an output handshake (out_valid_o & out_ready_i), the bit at idx_o SHALL be cleared in rem_q and seq_o SHALL increment by 1.
- If last_o=1, the next state SHALL be SCAN when a new vector is accepted in the same cycle, otherwise IDLE.
REQ-010 While out_valid_o=1 and out_ready_i=0, idx_o, seq_o, last_o and zero_o SHALL hold stable.
REQ-011 A vector with N set bits SHALL produce exactly N beats. seq_o SHALL run 0..N-1 and SHALL never wrap, since N <= WIDTH <= 2**CNT_WIDTH.
REQ-012 flush_i=1 SHALL clear rem_q and seq_o and force IDLE on the next edge. No handshake on either side is honoured in the flush cycle. flush_i SHALL take priority over every other event.
REQ-013 busy_o SHALL be 1 exactly in SCAN.
REQ-014 For WIDTH=1, CNT_WIDTH SHALL be 1, idx_o SHALL be constant 0, and one set bit SHALL yield a single beat with last_o=1.
REQ-015 An assertion SHALL fire if WIDTH < 1 (simulation only).

Reset
REQ-016 On a rising edge with rst_ni=0, the block SHALL enter IDLE with rem_q=0 and seq counter=0, regardless of the other inputs.
- Output values in the cycle after that edge SHALL be: in_ready_o=1 (unless flush_i), out_valid_o=0, idx_o=0, seq_o=0, last_o=0, zero_o=0, busy_o=0.
REQ-017 Reset asserted mid-vector SHALL discard the vector without emitting further beats.

Configuration
REQ-018 Macro BIT_SCAN_STREAM_ZERO_BEAT_EN SHALL control the handling of an accepted all-zero vector.
- Defined: the block SHALL emit one beat with zero_o=1, last_o=1, idx_o=0, seq_o=0.
- Undefined: the block SHALL consume the vector without emitting a beat, remain in IDLE, and tie zero_o to 0.

Verification
REQ-019 Bench SHALL cover (WIDTH=8):
- LSB order: MODE=0, in_i=8'b1010_0100, out_ready_i=1 -> idx_o 2,5,7 on three consecutive cycles, seq_o 0,1,2, last_o only on 7.
- MSB order: MODE=1, same vector -> idx_o 7,5,2, last_o on 2.
- Backpressure: MODE=0, in_i=8'h11, out_ready_i low for 3 cycles -> idx_o=0, seq_o=0 held stable for 3 cycles; then 0, 4 delivered.
- Back-to-back: 8'h80 then 8'h01 presented continuously -> 8'h01 accepted in the cycle of the last beat of 8'h80; next cycle idx_o=0, seq_o=0, no bubble.
- All-zero vector: in_i=8'h00 -> with macro, one beat with zero_o=1 and last_o=1; without macro, no beat, busy_o stays 0.
- Abort: 8'hFF with flush_i pulsed after 2 beats, and separately rst_ni low after 2 beats -> out_valid_o=0 next cycle, busy_o=0, no further beats; a following 8'h02 yields idx_o=1, seq_o=0.

Source files
------------

// File: rtl/bit_scan_stream.sv
// bit_scan_stream: accepts a vector and streams the positions of its set bits,
// one beat per cycle, lowest-first (MODE=0) or highest-first (MODE=1).
// Optional macro BIT_SCAN_STREAM_ZERO_BEAT_EN: an all-zero vector produces a
// single beat flagged with zero_o; without it such a vector is silently consumed.

package cf_math_pkg;
    // Bits needed to index n items; never less than 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

module bit_scan_stream #(
    parameter int WIDTH     = 8,
    parameter bit MODE      = 1'b0,
    parameter int CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CNT_WIDTH-1:0] idx_o,
    output logic [CNT_WIDTH-1:0] seq_o,
    output logic                 last_o,
    output logic                 zero_o,
    output logic                 busy_o
);

    typedef enum logic {IDLE, SCAN} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     sel;
    logic [CNT_WIDTH-1:0] seq_q, seq_d;
    logic [CNT_WIDTH-1:0] pos;
    logic                 scan, onehot, last_int, zero_beat, out_hs, in_hs;

`ifdef BIT_SCAN_STREAM_ZERO_BEAT_EN
    // Set while the single beat for an all-zero vector is outstanding.
    logic zero_q, zero_d;
    assign zero_beat = zero_q;
`else
    assign zero_beat = 1'b0;
`endif

    // Pick the next bit to report; the last match in loop order wins.
    always_comb begin
        sel = '0;
        pos = '0;
        if (MODE) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (rem_q[i]) begin
                    sel    = '0;
                    sel[i] = 1'b1;
                    pos    = CNT_WIDTH'(i);
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (rem_q[i]) begin
                    sel    = '0;
                    sel[i] = 1'b1;
                    pos    = CNT_WIDTH'(i);
                end
            end
        end
    end

    assign scan     = (state_q == SCAN);
    assign onehot   = (rem_q != '0) && ((rem_q & (rem_q - WIDTH'(1))) == '0);
    assign last_int = zero_beat | onehot;

    assign out_valid_o = scan & ~flush_i;
    assign idx_o       = out_valid_o ? pos : '0;
    assign seq_o       = out_valid_o ? seq_q : '0;
    assign last_o      = out_valid_o & last_int;
    assign zero_o      = out_valid_o & zero_beat;
    assign busy_o      = scan;

    assign out_hs     = out_valid_o & out_ready_i;
    // A new vector may land in the same cycle the previous one retires.
    assign in_ready_o = ~flush_i & (~scan | (out_hs & last_int));
    assign in_hs      = in_valid_i & in_ready_o;

    // Next-state: flush dominates, then retire a beat, then load a new vector.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
`ifdef BIT_SCAN_STREAM_ZERO_BEAT_EN
        zero_d  = zero_q;
`endif
        if (flush_i) begin
            state_d = IDLE;
            rem_d   = '0;
            seq_d   = '0;
`ifdef BIT_SCAN_STREAM_ZERO_BEAT_EN
            zero_d  = 1'b0;
`endif
        end else begin
            if (out_hs) begin
                rem_d = rem_q & ~sel;
                seq_d = seq_q + CNT_WIDTH'(1);
                if (last_int) begin
                    state_d = IDLE;
                    seq_d   = '0;
`ifdef BIT_SCAN_STREAM_ZERO_BEAT_EN
                    zero_d  = 1'b0;
`endif
                end
            end
            if (in_hs) begin
                rem_d = in_i;
                seq_d = '0;
`ifdef BIT_SCAN_STREAM_ZERO_BEAT_EN
                zero_d  = (in_i == '0);
                state_d = SCAN;
`else
                state_d = (in_i != '0) ? SCAN : IDLE;
`endif
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= '0;
            seq_q   <= '0;
`ifdef BIT_SCAN_STREAM_ZERO_BEAT_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
`ifdef BIT_SCAN_STREAM_ZERO_BEAT_EN
            zero_q  <= zero_d;
`endif
        end
    end

    // Guard against a degenerate vector width.
    always @(posedge clk_i) begin
        assert (WIDTH >= 1) else $error("bit_scan_stream: WIDTH must be >= 1");
    end

endmodule

// File: tb/tb_bit_scan_stream.sv
// Bench for bit_scan_stream: an LSB-first and an MSB-first instance share all
// inputs; directed scenarios use hand-derived values, the random run uses a
// beat-list reference model.
`timescale 1ns/1ps
module tb_bit_scan_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [1:0] rdy, ov, last, zero, busy;
    logic [1:0][2:0] idx, seq;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        bit_scan_stream #(.WIDTH(8), .MODE(m == 1)) dut (
            .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
            .in_valid_i(in_valid), .in_ready_o(rdy[m]), .in_i(in_data),
            .out_valid_o(ov[m]), .out_ready_i(out_ready),
            .idx_o(idx[m]), .seq_o(seq[m]), .last_o(last[m]),
            .zero_o(zero[m]), .busy_o(busy[m])
        );
    end

    // Reference model: each held vector is a list of pending beats per order.
    typedef struct { int idx; int seq; bit last; bit zero; } beat_t;
    beat_t q0[$], q1[$];
    int m_n, m_k;
    bit m_busy, m_last, m_out, m_in;

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q0.delete(); q1.delete();
        end else begin
            m_busy = q0.size() != 0;
            m_last = m_busy && q0[0].last;
            m_out  = m_busy && out_ready;
            m_in   = in_valid && (!m_busy || (m_out && m_last));
            if (m_out) begin void'(q0.pop_front()); void'(q1.pop_front()); end
            if (m_in) begin
                m_n = $countones(in_data);
                m_k = 0;
                for (int i = 0; i < 8; i++)
                    if (in_data[i]) begin q0.push_back('{i, m_k, m_k == m_n - 1, 1'b0}); m_k++; end
                m_k = 0;
                for (int i = 7; i >= 0; i--)
                    if (in_data[i]) begin q1.push_back('{i, m_k, m_k == m_n - 1, 1'b0}); m_k++; end
`ifdef BIT_SCAN_STREAM_ZERO_BEAT_EN
                if (m_n == 0) begin
                    q0.push_back('{0, 0, 1'b1, 1'b1});
                    q1.push_back('{0, 0, 1'b1, 1'b1});
                end
`endif
            end
        end
    end

    function automatic logic [10:0] got(input int m);
        return {rdy[m], ov[m], idx[m], seq[m], last[m], zero[m], busy[m]};
    endfunction

    // Packs {in_ready, out_valid, idx, seq, last, zero, busy}.
    function automatic logic [10:0] pk(input bit r, input bit v, input int i,
                                       input int s, input bit l, input bit z, input bit b);
        return {r, v, i[2:0], s[2:0], l, z, b};
    endfunction

    task automatic cyc;
        @(posedge clk); #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        cyc; cyc;
        in_valid = 1'b0; rst_n = 1'b1;
        sample;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (got(m) !== pk(1, 0, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset m%0d: got %h want %h", m, got(m), pk(1, 0, 0, 0, 0, 0, 0));
            end
        end
        flush = 1'b1;
        sample;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (rdy[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_flush_ready m%0d: got %b want 0", m, rdy[m]);
            end
        end
        cyc;
        flush = 1'b0;
    endtask

    task automatic test_order;
        int lsb[3] = '{2, 5, 7};
        int msb[3] = '{7, 5, 2};
        logic [10:0] e;
        in_valid = 1'b1; in_data = 8'hA4; out_ready = 1'b1;
        cyc;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample;
            for (int m = 0; m < 2; m++) begin
                e = pk(k == 2, 1, (m == 0) ? lsb[k] : msb[k], k, k == 2, 0, 1);
                vectors++;
                if (got(m) !== e) begin
                    miscompares++;
                    $display("FAIL order m%0d beat%0d: got %h want %h", m, k, got(m), e);
                end
            end
            cyc;
        end
        sample;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (got(m) !== pk(1, 0, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL order_idle m%0d: got %h want %h", m, got(m), pk(1, 0, 0, 0, 0, 0, 0));
            end
        end
        cyc;
    endtask

    task automatic test_backpressure;
        logic [10:0] e;
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
        cyc;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) out_ready = 1'b1;
            sample;
            for (int m = 0; m < 2; m++) begin
                if (k < 4) e = pk(0, 1, (m == 0) ? 0 : 4, 0, 0, 0, 1);
                else       e = pk(1, 1, (m == 0) ? 4 : 0, 1, 1, 0, 1);
                vectors++;
                if (got(m) !== e) begin
                    miscompares++;
                    $display("FAIL backpressure m%0d step%0d: got %h want %h", m, k, got(m), e);
                end
            end
            cyc;
        end
    endtask

    task automatic test_back_to_back;
        in_valid = 1'b1; in_data = 8'h80; out_ready = 1'b1;
        cyc;
        in_data = 8'h01;
        sample;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (got(m) !== pk(1, 1, 7, 0, 1, 0, 1)) begin
                miscompares++;
                $display("FAIL b2b_last m%0d: got %h want %h", m, got(m), pk(1, 1, 7, 0, 1, 0, 1));
            end
        end
        cyc;
        in_valid = 1'b0;
        sample;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (got(m) !== pk(1, 1, 0, 0, 1, 0, 1)) begin
                miscompares++;
                $display("FAIL b2b_next m%0d: got %h want %h", m, got(m), pk(1, 1, 0, 0, 1, 0, 1));
            end
        end
        cyc;
    endtask

    task automatic test_zero_vector;
        logic [10:0] e;
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        cyc;
        in_valid = 1'b0;
`ifdef BIT_SCAN_STREAM_ZERO_BEAT_EN
        e = pk(1, 1, 0, 0, 1, 1, 1);
`else
        e = pk(1, 0, 0, 0, 0, 0, 0);
`endif
        sample;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (got(m) !== e) begin
                miscompares++;
                $display("FAIL zero_vector m%0d: got %h want %h", m, got(m), e);
            end
        end
        cyc;
        sample;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (got(m) !== pk(1, 0, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL zero_after m%0d: got %h want %h", m, got(m), pk(1, 0, 0, 0, 0, 0, 0));
            end
        end
        cyc;
    endtask

    task automatic test_abort(input bit use_rst);
        logic [10:0] e;
        in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        cyc;
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample;
            for (int m = 0; m < 2; m++) begin
                e = pk(0, 1, (m == 0) ? k : 7 - k, k, 0, 0, 1);
                vectors++;
                if (got(m) !== e) begin
                    miscompares++;
                    $display("FAIL abort%0d_beat m%0d k%0d: got %h want %h", use_rst, m, k, got(m), e);
                end
            end
            cyc;
        end
        if (use_rst) rst_n = 1'b0;
        else begin
            flush = 1'b1; in_valid = 1'b1; in_data = 8'h10;
            sample;
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (got(m) !== pk(0, 0, 0, 0, 0, 0, 1)) begin
                    miscompares++;
                    $display("FAIL flush_cycle m%0d: got %h want %h", m, got(m), pk(0, 0, 0, 0, 0, 0, 1));
                end
            end
        end
        cyc;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample;
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (got(m) !== pk(1, 0, 0, 0, 0, 0, 0)) begin
                    miscompares++;
                    $display("FAIL abort%0d_idle m%0d: got %h want %h", use_rst, m, got(m), pk(1, 0, 0, 0, 0, 0, 0));
                end
            end
            cyc;
        end
        in_valid = 1'b1; in_data = 8'h02;
        cyc;
        in_valid = 1'b0;
        sample;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (got(m) !== pk(1, 1, 1, 0, 1, 0, 1)) begin
                miscompares++;
                $display("FAIL abort%0d_next m%0d: got %h want %h", use_rst, m, got(m), pk(1, 1, 1, 0, 1, 0, 1));
            end
        end
        cyc;
    endtask

    task automatic test_random;
        beat_t h;
        int sz;
        bit v;
        logic [10:0] e;
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = $urandom_range(0, 1) != 0;
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       in_data = 8'h00;
                1:       in_data = 8'(1) << $urandom_range(0, 7);
                default: in_data = 8'($urandom);
            endcase
            sample;
            for (int m = 0; m < 2; m++) begin
                h  = '{0, 0, 1'b0, 1'b0};
                sz = q0.size();
                if (sz > 0) h = (m == 0) ? q0[0] : q1[0];
                v = (sz > 0) && !flush;
                e = pk(!flush && (sz == 0 || (v && out_ready && h.last)), v,
                       v ? h.idx : 0, v ? h.seq : 0, v && h.last, v && h.zero, sz > 0);
                vectors++;
                if (got(m) !== e) begin
                    miscompares++;
                    $display("FAIL random m%0d cyc%0d: got %h want %h", m, c, got(m), e);
                end
            end
            cyc;
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_order;
        test_backpressure;
        test_back_to_back;
        test_zero_vector;
        test_abort(1'b0);
        test_abort(1'b1);
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
